// File: rtl/read_arb_pkg.sv
// Shared types and constants for the VRF read-stage arbiters.
// Latency: none (declarations only).
// Backpressure: not applicable.
package read_arb_pkg;

  // Default field widths of a VRF read request
  localparam int VS_W_DEF     = 5;
  localparam int OFFSET_W_DEF = 6;
  localparam int GROUP_W_DEF  = 4;
  localparam int SRC_W_DEF    = 4;
  localparam int INST_W_DEF   = 3;

  // Width of each per-port saturating grant counter
  localparam int GRANT_CNT_W = 16;

  // Full read-request payload as carried from a lane requestor to the VRF
  typedef struct packed {
    logic [VS_W_DEF-1:0]     vs;
    logic [OFFSET_W_DEF-1:0] offset;
    logic [GROUP_W_DEF-1:0]  group_index;
    logic [SRC_W_DEF-1:0]    read_source;
    logic [INST_W_DEF-1:0]   instruction_index;
  } read_req_t;

endpackage

// File: rtl/rr_pick_onehot.sv
// Round-robin pick: one-hot grant of the first request after index 'last'.
// Latency: purely combinational.
// Backpressure: none; caller qualifies the grant with its own accept.
module rr_pick_onehot #(
  parameter int N = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     grant
);

  logic found;

  // Scan last+1, last+2, ... wrapping modulo N; first requester wins
  always_comb begin
    int pos;
    grant = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 1; k <= N; k++) begin
      pos = int'(last) + k;
      if (pos >= N) pos = pos - N;
      if (!found && req[pos[IDX_W-1:0]]) begin
        grant[pos[IDX_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/read_stage_rr_arbiter_n.sv
// N-input round-robin arbiter for VRF read requests with one registered output stage.
// Latency: 1 cycle from input accept to io_out_valid; full throughput of 1 request/cycle.
// Backpressure: while the output entry is stalled all io_in_ready drop and payload/priority hold.
// Optional build macro READ_ARB_GRANT_CNT_EN adds io_grant_cnt (per-port saturating transfer counters).
module read_stage_rr_arbiter_n
  import read_arb_pkg::*;
#(
  parameter int N_PORTS  = 4,
  parameter int VS_W     = VS_W_DEF,
  parameter int OFFSET_W = OFFSET_W_DEF,
  parameter int GROUP_W  = GROUP_W_DEF,
  parameter int SRC_W    = SRC_W_DEF,
  parameter int INST_W   = INST_W_DEF
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N_PORTS-1:0]           io_in_valid,
  output logic [N_PORTS-1:0]           io_in_ready,
  input  logic [N_PORTS*VS_W-1:0]      io_in_vs,
  input  logic [N_PORTS*OFFSET_W-1:0]  io_in_offset,
  input  logic [N_PORTS*GROUP_W-1:0]   io_in_group_index,
  input  logic [N_PORTS*SRC_W-1:0]     io_in_read_source,
  input  logic [N_PORTS*INST_W-1:0]    io_in_instruction_index,
  input  logic                         io_out_ready,
  output logic                         io_out_valid,
  output logic [VS_W-1:0]              io_out_vs,
  output logic [OFFSET_W-1:0]          io_out_offset,
  output logic [GROUP_W-1:0]           io_out_group_index,
  output logic [SRC_W-1:0]             io_out_read_source,
  output logic [INST_W-1:0]            io_out_instruction_index,
  output logic [N_PORTS-1:0]           io_out_grant
`ifdef READ_ARB_GRANT_CNT_EN
  ,
  output logic [N_PORTS*GRANT_CNT_W-1:0] io_grant_cnt
`endif
);

  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_PORTS - 1);

  logic [IDX_W-1:0]    last_q;
  logic                out_valid_q;
  logic [N_PORTS-1:0]  grant;
  logic [IDX_W-1:0]    grant_idx;
  logic                can_accept;
  logic                xfer;
  logic [VS_W-1:0]     sel_vs;
  logic [OFFSET_W-1:0] sel_offset;
  logic [GROUP_W-1:0]  sel_group_index;
  logic [SRC_W-1:0]    sel_read_source;
  logic [INST_W-1:0]   sel_instruction_index;

  rr_pick_onehot #(.N(N_PORTS)) u_pick (
    .req   (io_in_valid),
    .last  (last_q),
    .grant (grant)
  );

  // The stage takes a new entry when empty or when the current one drains this cycle
  assign can_accept   = !out_valid_q | io_out_ready;
  assign io_in_ready  = grant & {N_PORTS{can_accept}};
  // Grant is only ever set on a valid port, so any ready bit means a transfer
  assign xfer         = |io_in_ready;
  assign io_out_valid = out_valid_q;

  // Select the granted port's payload and encode its index for the priority pointer
  always_comb begin
    grant_idx             = '0;
    sel_vs                = '0;
    sel_offset            = '0;
    sel_group_index       = '0;
    sel_read_source       = '0;
    sel_instruction_index = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant[i]) begin
        grant_idx             = IDX_W'(i);
        sel_vs                = io_in_vs[i*VS_W +: VS_W];
        sel_offset            = io_in_offset[i*OFFSET_W +: OFFSET_W];
        sel_group_index       = io_in_group_index[i*GROUP_W +: GROUP_W];
        sel_read_source       = io_in_read_source[i*SRC_W +: SRC_W];
        sel_instruction_index = io_in_instruction_index[i*INST_W +: INST_W];
      end
    end
  end

  // Output stage: fill on transfer (also replaces a draining entry), clear on drain, hold on stall
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q              <= 1'b0;
      io_out_grant             <= '0;
      io_out_vs                <= '0;
      io_out_offset            <= '0;
      io_out_group_index       <= '0;
      io_out_read_source       <= '0;
      io_out_instruction_index <= '0;
      last_q                   <= LAST_RST;
    end else if (xfer) begin
      out_valid_q              <= 1'b1;
      io_out_grant             <= grant;
      io_out_vs                <= sel_vs;
      io_out_offset            <= sel_offset;
      io_out_group_index       <= sel_group_index;
      io_out_read_source       <= sel_read_source;
      io_out_instruction_index <= sel_instruction_index;
      last_q                   <= grant_idx;
    end else if (io_out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef READ_ARB_GRANT_CNT_EN
  localparam logic [GRANT_CNT_W-1:0] CNT_ONE = GRANT_CNT_W'(1);

  // Count accepted transfers per port, saturating at all-ones
  always_ff @(posedge clock) begin
    if (reset) begin
      io_grant_cnt <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (io_in_valid[i] && io_in_ready[i] &&
            (io_grant_cnt[i*GRANT_CNT_W +: GRANT_CNT_W] != '1)) begin
          io_grant_cnt[i*GRANT_CNT_W +: GRANT_CNT_W] <=
            io_grant_cnt[i*GRANT_CNT_W +: GRANT_CNT_W] + CNT_ONE;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_read_stage_rr_arbiter_n.sv
// Directed bench for read_stage_rr_arbiter_n (4 ports, default widths).
// Table rows are applied one per cycle; ready is sampled before the edge, registered outputs show the prior row's result.
// Hand sequences cover payload hold under a stall and, when READ_ARB_GRANT_CNT_EN is defined, counter saturation.
module tb_read_stage_rr_arbiter_n;

  localparam int N = 4;

  logic          clock;
  logic          reset;
  logic [N-1:0]  io_in_valid;
  logic [N-1:0]  io_in_ready;
  logic [N*5-1:0] io_in_vs;
  logic [N*6-1:0] io_in_offset;
  logic [N*4-1:0] io_in_group_index;
  logic [N*4-1:0] io_in_read_source;
  logic [N*3-1:0] io_in_instruction_index;
  logic          io_out_ready;
  logic          io_out_valid;
  logic [4:0]    io_out_vs;
  logic [5:0]    io_out_offset;
  logic [3:0]    io_out_group_index;
  logic [3:0]    io_out_read_source;
  logic [2:0]    io_out_instruction_index;
  logic [N-1:0]  io_out_grant;
`ifdef READ_ARB_GRANT_CNT_EN
  logic [N*16-1:0] io_grant_cnt;
`endif

  read_stage_rr_arbiter_n #(.N_PORTS(N)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .io_in_valid              (io_in_valid),
    .io_in_ready              (io_in_ready),
    .io_in_vs                 (io_in_vs),
    .io_in_offset             (io_in_offset),
    .io_in_group_index        (io_in_group_index),
    .io_in_read_source        (io_in_read_source),
    .io_in_instruction_index  (io_in_instruction_index),
    .io_out_ready             (io_out_ready),
    .io_out_valid             (io_out_valid),
    .io_out_vs                (io_out_vs),
    .io_out_offset            (io_out_offset),
    .io_out_group_index       (io_out_group_index),
    .io_out_read_source       (io_out_read_source),
    .io_out_instruction_index (io_out_instruction_index),
    .io_out_grant             (io_out_grant)
`ifdef READ_ARB_GRANT_CNT_EN
    ,
    .io_grant_cnt             (io_grant_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] e_rdy;
    logic       e_ov;
    logic [3:0] e_og;
    logic       chk;   // compare grant and payload on this row
  } vec_t;

  vec_t tbl[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Port i payload: vs=15+i, offset=31+i, group=7+i, source=i+1, inst=i (port 2 -> 17/33/9)
  function automatic logic [21:0] port_pay(input int i);
    logic [4:0] v; logic [5:0] o; logic [3:0] g; logic [3:0] s; logic [2:0] n;
    v = 5'(15 + i); o = 6'(31 + i); g = 4'(7 + i); s = 4'(i + 1); n = 3'(i);
    return {v, o, g, s, n};
  endfunction

  function automatic logic [21:0] exp_pay(input logic [3:0] og);
    logic [21:0] p;
    p = '0;
    for (int i = 0; i < N; i++) if (og[i]) p = port_pay(i);
    return p;
  endfunction

  task automatic set_payload();
    logic [21:0] p;
    for (int i = 0; i < N; i++) begin
      p = port_pay(i);
      io_in_vs[i*5 +: 5]                = p[21:17];
      io_in_offset[i*6 +: 6]            = p[16:11];
      io_in_group_index[i*4 +: 4]       = p[10:7];
      io_in_read_source[i*4 +: 4]       = p[6:3];
      io_in_instruction_index[i*3 +: 3] = p[2:0];
    end
  endtask

  logic [21:0] act_pay;
  assign act_pay = {io_out_vs, io_out_offset, io_out_group_index,
                    io_out_read_source, io_out_instruction_index};

  initial begin
    //            rst  vld    ordy e_rdy  e_ov e_og   chk
    tbl[0]  = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b1}; // reset state
    tbl[1]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b0, 4'h0, 1'b1}; // all valid, port 0 first
    tbl[2]  = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 4'h1, 1'b1};
    tbl[3]  = '{1'b0, 4'hF, 1'b1, 4'h4, 1'b1, 4'h2, 1'b1};
    tbl[4]  = '{1'b0, 4'hF, 1'b1, 4'h8, 1'b1, 4'h4, 1'b1};
    tbl[5]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 4'h8, 1'b1}; // wraps to 0
    tbl[6]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 4'h1, 1'b1}; // idle, entry drains
    tbl[7]  = '{1'b0, 4'h4, 1'b1, 4'h4, 1'b0, 4'h0, 1'b0}; // only port 2
    tbl[8]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 4'h4, 1'b1}; // vs=17 out
    tbl[9]  = '{1'b0, 4'h1, 1'b0, 4'h1, 1'b0, 4'h0, 1'b0}; // empty stage accepts; last=0
    tbl[10] = '{1'b0, 4'hA, 1'b0, 4'h0, 1'b1, 4'h1, 1'b1}; // stall 1
    tbl[11] = '{1'b0, 4'hA, 1'b0, 4'h0, 1'b1, 4'h1, 1'b1}; // stall 2
    tbl[12] = '{1'b0, 4'hA, 1'b0, 4'h0, 1'b1, 4'h1, 1'b1}; // stall 3
    tbl[13] = '{1'b0, 4'hA, 1'b1, 4'h2, 1'b1, 4'h1, 1'b1}; // release: port 1
    tbl[14] = '{1'b0, 4'hA, 1'b1, 4'h8, 1'b1, 4'h2, 1'b1}; // then port 3
    tbl[15] = '{1'b0, 4'h9, 1'b1, 4'h1, 1'b1, 4'h8, 1'b1}; // last=3, ports 0,3 -> 0
    tbl[16] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 4'h1, 1'b1}; // stalled entry
    tbl[17] = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 4'h1, 1'b1}; // reset while stalled
    tbl[18] = '{1'b0, 4'hF, 1'b0, 4'h1, 1'b0, 4'h0, 1'b1}; // entry dropped, port 0 first
    tbl[19] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 4'h1, 1'b1};
    tbl[20] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0};

    reset        = 1'b1;
    io_in_valid  = '0;
    io_out_ready = 1'b1;
    set_payload();
    repeat (2) @(posedge clock);

    for (int r = 0; r < 21; r++) begin
      @(posedge clock);
      #1;
      reset        = tbl[r].rst;
      io_in_valid  = tbl[r].vld;
      io_out_ready = tbl[r].ordy;
      @(negedge clock);
      check($sformatf("row%0d in_ready", r), 32'(io_in_ready), 32'(tbl[r].e_rdy));
      check($sformatf("row%0d out_valid", r), 32'(io_out_valid), 32'(tbl[r].e_ov));
      if (tbl[r].chk) begin
        check($sformatf("row%0d out_grant", r), 32'(io_out_grant), 32'(tbl[r].e_og));
        check($sformatf("row%0d payload", r), 32'(act_pay), 32'(exp_pay(tbl[r].e_og)));
      end
    end

    // Payload must hold while stalled even when the source changes its data
    @(posedge clock); #1;
    io_in_vs[4:0] = 5'd3;
    io_in_valid   = 4'h1;
    io_out_ready  = 1'b1;
    @(negedge clock);
    check("hold accept ready", 32'(io_in_ready), 32'h1);
    @(posedge clock); #1;
    io_in_vs[4:0] = 5'd29;
    io_out_ready  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check($sformatf("hold%0d in_ready", c), 32'(io_in_ready), 32'h0);
      check($sformatf("hold%0d out_vs", c), 32'(io_out_vs), 32'd3);
      check($sformatf("hold%0d out_valid", c), 32'(io_out_valid), 32'h1);
      @(posedge clock); #1;
    end
    io_out_ready = 1'b1;
    @(negedge clock);
    check("release in_ready", 32'(io_in_ready), 32'h1);
    @(posedge clock); #1;
    io_in_valid = '0;
    @(negedge clock);
    check("release out_vs", 32'(io_out_vs), 32'd29);
    check("release out_grant", 32'(io_out_grant), 32'h1);
    set_payload();

`ifdef READ_ARB_GRANT_CNT_EN
    // Saturate port 1's counter; others must stay at zero
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset        = 1'b0;
    io_in_valid  = 4'h2;
    io_out_ready = 1'b1;
    repeat (70000) @(posedge clock);
    #1;
    io_in_valid = '0;
    @(negedge clock);
    check("cnt port0", 32'(io_grant_cnt[15:0]),  32'h0);
    check("cnt port1", 32'(io_grant_cnt[31:16]), 32'hFFFF);
    check("cnt port2", 32'(io_grant_cnt[47:32]), 32'h0);
    check("cnt port3", 32'(io_grant_cnt[63:48]), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
